slice_coeff_seq: RTL and testbench

SLICE_COEFF_SEQ -- requirements
Module: slice_coeff_seq

---
 rtl/slice_coeff_seq_if.sv | 23 ++
 rtl/slice_coeff_seq.sv | 83 ++++++++
 tb/tb_slice_coeff_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/slice_coeff_seq_if.sv
// slice_coeff_seq_if: load/pixel bus between the coefficient sequencer and its producer/consumer.
// SUMW (checksum width) exists only when SLICE_COEFF_CHECKSUM_EN is defined.
interface slice_coeff_seq_if #(
  parameter int CWIDTH = 9
`ifdef SLICE_COEFF_CHECKSUM_EN
  , parameter int SUMW = 17
`endif
);
  logic load_start, load_we, sof, dvi, newblock, download, ready;
  logic signed [CWIDTH-1:0] load_data, svcoeff;
`ifdef SLICE_COEFF_CHECKSUM_EN
  logic signed [SUMW-1:0] coeff_sum;
  modport master (output load_start, load_we, load_data, sof, dvi,
                  input svcoeff, newblock, download, ready, coeff_sum);
  modport slave (input load_start, load_we, load_data, sof, dvi,
                 output svcoeff, newblock, download, ready, coeff_sum);
`else
  modport master (output load_start, load_we, load_data, sof, dvi,
                  input svcoeff, newblock, download, ready);
  modport slave (input load_start, load_we, load_data, sof, dvi,
                 output svcoeff, newblock, download, ready);
`endif
endinterface

// File: rtl/slice_coeff_seq.sv
// slice_coeff_seq: loads a window of signed coefficients, flushes the slice memory, then streams one coefficient per pixel.
// SLICE_COEFF_CHECKSUM_EN adds coeff_sum, the running sum of coefficients written since the last load_start.
module slice_coeff_seq #(
  parameter int CWIDTH    = 9,
  parameter int BLOCKSIZE = 32,
  parameter int WINCOLS   = 8,
  parameter int WPI       = 40
)(
  input logic clk,
  input logic reset_n,
  slice_coeff_seq_if.slave bus
);
  localparam int NCOEFF = BLOCKSIZE * WINCOLS;
  localparam int AW = $clog2(NCOEFF);
  localparam int BW = $clog2(BLOCKSIZE);
  localparam int FW = $clog2(WPI + 1);
  localparam logic [1:0] EMPTY = 2'd0, LOAD = 2'd1, FLUSH = 2'd2, RUN = 2'd3;
  logic [1:0] state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic signed [CWIDTH-1:0] svcoeff_q;
  logic download_q, we, rd_en;
  logic signed [CWIDTH-1:0] mem [NCOEFF];
  assign we = bus.load_we && state_q == LOAD && !bus.load_start;
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fcnt_d  = fcnt_q;
    rd_en   = 1'b0;
    if (bus.load_start) begin
      state_d = LOAD;
      wptr_d  = '0;
      fcnt_d  = '0;
    end else if (state_q == LOAD) begin
      wptr_d  = bus.load_we ? wptr_q + 1'b1 : wptr_q;
      state_d = (bus.load_we && wptr_q == AW'(NCOEFF - 1)) ? FLUSH : LOAD;
    end else if (state_q == FLUSH) begin
      fcnt_d = fcnt_q + 1'b1;
      if (fcnt_q == FW'(WPI - 1)) begin
        state_d = RUN;
        fcnt_d  = '0;
        rptr_d  = '0;
        rd_en   = 1'b1;
      end
    end else if (state_q == RUN) begin
      rptr_d = bus.sof ? '0 : bus.dvi ? rptr_q + 1'b1 : rptr_q;
      rd_en  = bus.sof || bus.dvi;
    end
  end
  always_ff @(posedge clk)
    if (we) mem[wptr_q] <= bus.load_data;
  // svcoeff_q doubles as the RAM's registered read port, prefetching the next pixel's coefficient
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= EMPTY;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fcnt_q     <= '0;
      svcoeff_q  <= '0;
      download_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fcnt_q     <= fcnt_d;
      download_q <= state_d == LOAD || state_d == FLUSH;
      if (bus.load_start) svcoeff_q <= '0;
      else if (rd_en) svcoeff_q <= mem[rptr_d];
    end
  assign bus.svcoeff  = svcoeff_q;
  assign bus.download = download_q;
  assign bus.ready    = state_q == RUN;
  assign bus.newblock = bus.dvi && state_q == RUN && &rptr_q[BW-1:0];
`ifdef SLICE_COEFF_CHECKSUM_EN
  logic signed [CWIDTH+AW-1:0] sum_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sum_q <= '0;
    else if (bus.load_start) sum_q <= '0;
    else if (we) sum_q <= sum_q + (CWIDTH + AW)'(bus.load_data);
  assign bus.coeff_sum = sum_q;
`endif
endmodule

// File: tb/tb_slice_coeff_seq.sv
// tb_slice_coeff_seq: directed vectors; pixel results checked by a scoreboard monitor on each qualified dvi.
module tb_slice_coeff_seq;
  localparam int CW = 9, BS = 4, WC = 2, WP = 5;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  slice_coeff_seq_if #(
    .CWIDTH(CW)
`ifdef SLICE_COEFF_CHECKSUM_EN
    , .SUMW(CW + 3)
`endif
  ) bus ();
  slice_coeff_seq #(.CWIDTH(CW), .BLOCKSIZE(BS), .WINCOLS(WC), .WPI(WP)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  typedef struct {int coeff; int nb;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pix(int c, int nb);
    q.push_back('{coeff: c, nb: nb});
    bus.dvi = 1'b1;
    tick();
    bus.dvi = 1'b0;
  endtask
  task automatic start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask
  task automatic wr(int v);
    bus.load_we = 1'b1;
    bus.load_data = CW'(v);
    tick();
    bus.load_we = 1'b0;
  endtask
  task automatic flush_chk();
    for (int f = 0; f < WP; f++) begin
      chk("flush_download", bus.download, 1);
      chk("flush_ready", bus.ready, 0);
      tick();
    end
    chk("run_ready", bus.ready, 1);
    chk("run_download", bus.download, 0);
  endtask
  exp_t e;
  always @(negedge clk)
    if (reset_n && bus.dvi && bus.ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got svcoeff %0d, expected no pixel", bus.svcoeff);
      end else begin
        e = q.pop_front();
        chk("pixel_svcoeff", bus.svcoeff, e.coeff);
        chk("pixel_newblock", bus.newblock, e.nb);
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.load_start = 0; bus.load_we = 0; bus.load_data = '0; bus.sof = 0; bus.dvi = 1;
    repeat (2) tick();
    chk("rst_ready", bus.ready, 0);
    chk("rst_download", bus.download, 0);
    chk("rst_svcoeff", bus.svcoeff, 0);
    chk("rst_newblock", bus.newblock, 0);
    reset_n = 1'b1;
    tick();
    chk("empty_svcoeff", bus.svcoeff, 0);
    chk("empty_newblock", bus.newblock, 0);
    bus.dvi = 1'b0;
    start();
    chk("load_download", bus.download, 1);
    chk("load_svcoeff", bus.svcoeff, 0);
    for (int i = 0; i < 8; i++) wr(i - 4);
    flush_chk();
    chk("run_svcoeff0", bus.svcoeff, -4);
`ifdef SLICE_COEFF_CHECKSUM_EN
    chk("sum_first", bus.coeff_sum, -4);
`endif
    for (int i = 0; i < 10; i++) pix(i % 8 - 4, int'(i % 4 == 3));
    bus.sof = 1'b1; tick(); bus.sof = 1'b0;
    pix(-4, 0); pix(-3, 0); pix(-2, 0);
    bus.sof = 1'b1; tick(); bus.sof = 1'b0;
    pix(-4, 0); pix(-3, 0); pix(-2, 0); pix(-1, 1); pix(0, 0);
    q.push_back('{coeff: 1, nb: 0});
    bus.sof = 1'b1; bus.dvi = 1'b1; tick(); bus.sof = 1'b0; bus.dvi = 1'b0;
    pix(-4, 0);
    start();
    chk("abort_svcoeff", bus.svcoeff, 0);
    chk("abort_ready", bus.ready, 0);
    chk("abort_download", bus.download, 1);
    for (int i = 0; i < 5; i++) wr(7);
    bus.load_we = 1'b1; bus.load_data = CW'(100);
    start();
    bus.load_we = 1'b0;
    for (int i = 0; i < 8; i++) wr(1);
    flush_chk();
    chk("reload_svcoeff", bus.svcoeff, 1);
`ifdef SLICE_COEFF_CHECKSUM_EN
    chk("sum_reload", bus.coeff_sum, 8);
`endif
    wr(5);
    for (int i = 0; i < 9; i++) pix(1, int'(i % 4 == 3));
    start();
    for (int i = 0; i < 8; i++) wr(10 + i);
    tick();
    reset_n = 1'b0;
    #1;
    chk("midflush_download", bus.download, 0);
    chk("midflush_ready", bus.ready, 0);
    chk("midflush_svcoeff", bus.svcoeff, 0);
    tick();
    reset_n = 1'b1;
    bus.dvi = 1'b1;
    repeat (3) begin
      tick();
      chk("postrst_ready", bus.ready, 0);
      chk("postrst_svcoeff", bus.svcoeff, 0);
      chk("postrst_newblock", bus.newblock, 0);
    end
    bus.dvi = 1'b0;
    start();
    for (int i = 0; i < 8; i++) wr(-100 + i);
    flush_chk();
    chk("final_svcoeff", bus.svcoeff, -100);
    pix(-100, 0); pix(-99, 0); pix(-98, 0); pix(-97, 1);
    tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
